// File: rtl/mult_wb_merge.sv
`default_nettype none
// ============================================================================
// Module   : mult_wb_merge
// Purpose  : Merges the multiplier result stream with main-pipeline writeback
//            onto the single register-file write port. The main pipeline has
//            priority. Displaced multiply results wait in a small FIFO.
//            A younger main write cancels queued multiply writes that target
//            the same register.
// Options  : MULT_WB_FLAGS_EN - store zero/overflow flags per entry and drive
//            them on rf_zero/rf_overflow with multiply writes.
// Revision : 1.0 - initial release
// ============================================================================
module mult_wb_merge #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int AFULL  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regwrite_wb_in,
  input  logic [ADDR_W-1:0] wreg_wb_in,
  input  logic [DATA_W-1:0] wb_data_in,
  input  logic              regwrite_mult_in,
  input  logic [ADDR_W-1:0] wreg_mult_in,
  input  logic [DATA_W-1:0] mult_result_in,
  input  logic              mult_zero_in,
  input  logic              mult_overflow_in,
  input  logic [ADDR_W-1:0] query_reg,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_zero,
  output logic              rf_overflow,
  output logic              rf_from_mult,
  output logic              mult_afull,
  output logic              pending_hit,
  output logic              fifo_ovf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_afull_cnt = CNT_W'(AFULL);

  // FIFO storage and bookkeeping
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W-1:0]  r_wptr;
  logic [CNT_W-1:0]  r_count;

`ifdef MULT_WB_FLAGS_EN
  logic [DEPTH-1:0]  r_zero_q;
  logic [DEPTH-1:0]  r_ovf_q;
`endif

  logic              w_main_req;
  logic              w_mult_req;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push_try;
  logic              w_push;
  logic              w_push_valid;
  logic              w_drop;
  logic [CNT_W-1:0]  w_cnt_nxt;

  // Writes to register 0 are architecturally meaningless and treated as absent
  assign w_main_req   = regwrite_wb_in && (wreg_wb_in != '0);
  assign w_mult_req   = regwrite_mult_in && (wreg_mult_in != '0);
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == c_depth_cnt);
  // The head drains only when the main pipeline leaves the port free
  assign w_pop        = !w_main_req && !w_empty;
  // A multiply result is queued whenever it cannot bypass straight to the port
  assign w_push_try   = w_mult_req && (w_main_req || !w_empty);
  assign w_push       = w_push_try && (!w_full || w_pop);
  assign w_drop       = w_push_try && w_full && !w_pop;
  // Same-cycle collision: the multiply is older, so the main write supersedes it
  assign w_push_valid = !(w_main_req && (wreg_mult_in == wreg_wb_in));

  // Next occupancy from this cycle's push/pop pair
  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_count - CNT_W'(1);
    end
  end

  // Pointers, occupancy and per-entry valid bits (kill, pop, then push)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_main_req) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_addr[i] == wreg_wb_in) begin
            r_valid[i] <= 1'b0;
          end
        end
      end
      if (w_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + PTR_W'(1);
      end
      // Push last so a full-FIFO pop+push into the same slot keeps the new entry
      if (w_push) begin
        r_valid[r_wptr] <= w_push_valid;
        r_wptr          <= r_wptr + PTR_W'(1);
      end
      r_count <= w_cnt_nxt;
    end
  end

  // Entry payload; contents are qualified by r_valid so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= wreg_mult_in;
      r_data[r_wptr] <= mult_result_in;
`ifdef MULT_WB_FLAGS_EN
      r_zero_q[r_wptr] <= mult_zero_in;
      r_ovf_q[r_wptr]  <= mult_overflow_in;
`endif
    end
  end

  // Register-file port arbitration: main, then FIFO head, then bypass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      rf_from_mult <= 1'b0;
      mult_afull   <= 1'b0;
      fifo_ovf     <= 1'b0;
`ifdef MULT_WB_FLAGS_EN
      rf_zero      <= 1'b0;
      rf_overflow  <= 1'b0;
`endif
    end else begin
      rf_we        <= 1'b0;
      rf_from_mult <= 1'b0;
`ifdef MULT_WB_FLAGS_EN
      rf_zero      <= 1'b0;
      rf_overflow  <= 1'b0;
`endif
      if (w_main_req) begin
        rf_we    <= 1'b1;
        rf_waddr <= wreg_wb_in;
        rf_wdata <= wb_data_in;
      end else if (w_pop) begin
        // A killed head still consumes its slot but produces an idle cycle
        if (r_valid[r_rptr]) begin
          rf_we        <= 1'b1;
          rf_waddr     <= r_addr[r_rptr];
          rf_wdata     <= r_data[r_rptr];
          rf_from_mult <= 1'b1;
`ifdef MULT_WB_FLAGS_EN
          rf_zero      <= r_zero_q[r_rptr];
          rf_overflow  <= r_ovf_q[r_rptr];
`endif
        end
      end else if (w_mult_req) begin
        rf_we        <= 1'b1;
        rf_waddr     <= wreg_mult_in;
        rf_wdata     <= mult_result_in;
        rf_from_mult <= 1'b1;
`ifdef MULT_WB_FLAGS_EN
        rf_zero      <= mult_zero_in;
        rf_overflow  <= mult_overflow_in;
`endif
      end
      mult_afull <= (w_cnt_nxt >= c_afull_cnt);
      fifo_ovf   <= fifo_ovf | w_drop;
    end
  end

`ifndef MULT_WB_FLAGS_EN
  logic w_unused_flags;
  assign w_unused_flags = mult_zero_in ^ mult_overflow_in;
  assign rf_zero        = 1'b0;
  assign rf_overflow    = 1'b0;
`endif

  // Hazard lookup: queued entries that survive this cycle's kill
  always_comb begin
    pending_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == query_reg) &&
          !(w_main_req && (r_addr[i] == wreg_wb_in))) begin
        pending_hit = 1'b1;
      end
    end
    if (query_reg == '0) begin
      pending_hit = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_wb_merge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_wb_merge
// Purpose  : Self-checking bench for mult_wb_merge: directed scenarios with
//            literal expectations plus randomized traffic compared every cycle
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_wb_merge;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int AFULL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          regwrite_wb_in = 1'b0;
  logic [AW-1:0] wreg_wb_in = '0;
  logic [DW-1:0] wb_data_in = '0;
  logic          regwrite_mult_in = 1'b0;
  logic [AW-1:0] wreg_mult_in = '0;
  logic [DW-1:0] mult_result_in = '0;
  logic          mult_zero_in = 1'b0;
  logic          mult_overflow_in = 1'b0;
  logic [AW-1:0] query_reg = '0;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          rf_zero;
  logic          rf_overflow;
  logic          rf_from_mult;
  logic          mult_afull;
  logic          pending_hit;
  logic          fifo_ovf;

  always #5 clk = ~clk;

  mult_wb_merge #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .AFULL(AFULL)) dut (
    .clk(clk), .rst_n(rst_n),
    .regwrite_wb_in(regwrite_wb_in), .wreg_wb_in(wreg_wb_in), .wb_data_in(wb_data_in),
    .regwrite_mult_in(regwrite_mult_in), .wreg_mult_in(wreg_mult_in),
    .mult_result_in(mult_result_in), .mult_zero_in(mult_zero_in),
    .mult_overflow_in(mult_overflow_in), .query_reg(query_reg),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_zero(rf_zero),
    .rf_overflow(rf_overflow), .rf_from_mult(rf_from_mult), .mult_afull(mult_afull),
    .pending_hit(pending_hit), .fifo_ovf(fifo_ovf)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a queue of pending multiply writes -----
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            v;
    bit            z;
    bit            o;
  } ent_t;

  ent_t          q[$];
  ent_t          m_e;
  bit            m_mreq, m_xreq, m_busy;
  bit            exp_we = 0, exp_from = 0, exp_z = 0, exp_o = 0;
  bit            exp_afull = 0, exp_ovf = 0;
  logic [AW-1:0] exp_waddr = '0;
  logic [DW-1:0] exp_wdata = '0;

  function automatic bit model_pending();
    bit mreq;
    mreq = regwrite_wb_in && (wreg_wb_in != 0);
    model_pending = 1'b0;
    if (query_reg != 0) begin
      foreach (q[i]) begin
        if (q[i].v && q[i].a == query_reg && !(mreq && q[i].a == wreg_wb_in))
          model_pending = 1'b1;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exp_we = 0; exp_from = 0; exp_z = 0; exp_o = 0;
      exp_afull = 0; exp_ovf = 0; exp_waddr = '0; exp_wdata = '0;
    end else begin
      m_mreq = regwrite_wb_in && (wreg_wb_in != 0);
      m_xreq = regwrite_mult_in && (wreg_mult_in != 0);
      m_busy = m_mreq || (q.size() != 0);
      exp_we = 0; exp_from = 0; exp_z = 0; exp_o = 0;
      if (m_mreq) begin
        exp_we = 1; exp_waddr = wreg_wb_in; exp_wdata = wb_data_in;
        foreach (q[i]) if (q[i].a == wreg_wb_in) q[i].v = 0;
      end else if (q.size() != 0) begin
        m_e = q.pop_front();
        if (m_e.v) begin
          exp_we = 1; exp_from = 1; exp_waddr = m_e.a; exp_wdata = m_e.d;
`ifdef MULT_WB_FLAGS_EN
          exp_z = m_e.z; exp_o = m_e.o;
`endif
        end
      end else if (m_xreq) begin
        exp_we = 1; exp_from = 1; exp_waddr = wreg_mult_in; exp_wdata = mult_result_in;
`ifdef MULT_WB_FLAGS_EN
        exp_z = mult_zero_in; exp_o = mult_overflow_in;
`endif
      end
      if (m_xreq && m_busy) begin
        if (q.size() < DEPTH) begin
          m_e.a = wreg_mult_in; m_e.d = mult_result_in;
          m_e.v = !(m_mreq && wreg_mult_in == wreg_wb_in);
          m_e.z = mult_zero_in; m_e.o = mult_overflow_in;
          q.push_back(m_e);
        end else begin
          exp_ovf = 1;
        end
      end
      exp_afull = (q.size() >= AFULL);
    end
  end

  // ---------------- compare process: every cycle on the falling edge --------
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("m_rf_we",       rf_we,        exp_we);
      chk("m_rf_waddr",    rf_waddr,     exp_waddr);
      chk("m_rf_wdata",    rf_wdata,     exp_wdata);
      chk("m_rf_from_mult", rf_from_mult, exp_from);
      chk("m_rf_zero",     rf_zero,      exp_z);
      chk("m_rf_overflow", rf_overflow,  exp_o);
      chk("m_mult_afull",  mult_afull,   exp_afull);
      chk("m_fifo_ovf",    fifo_ovf,     exp_ovf);
      chk("m_pending_hit", pending_hit,  model_pending());
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit mw, input int ma, input logic [DW-1:0] md,
                       input bit xw, input int xa, input logic [DW-1:0] xd,
                       input bit z, input bit o);
    regwrite_wb_in   = mw;  wreg_wb_in   = AW'(ma); wb_data_in     = md;
    regwrite_mult_in = xw;  wreg_mult_in = AW'(xa); mult_result_in = xd;
    mult_zero_in     = z;   mult_overflow_in = o;
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0, '0, 0, 0);
  endtask

  bit exp_flag_o;

  initial begin
`ifdef MULT_WB_FLAGS_EN
    exp_flag_o = 1'b1;
`else
    exp_flag_o = 1'b0;
`endif
    idle();
    #1;
    chk("reset_rf_we",    rf_we,      1'b0);
    chk("reset_waddr",    rf_waddr,   '0);
    chk("reset_wdata",    rf_wdata,   '0);
    chk("reset_afull",    mult_afull, 1'b0);
    chk("reset_ovf",      fifo_ovf,   1'b0);
    tick();
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Bypass only
    drive(0, 0, '0, 1, 3, 32'h10, 0, 1);
    tick();
    chk("bypass_we",   rf_we,        1'b1);
    chk("bypass_addr", rf_waddr,     5'd3);
    chk("bypass_data", rf_wdata,     32'h10);
    chk("bypass_from", rf_from_mult, 1'b1);
    chk("bypass_ovf",  rf_overflow,  exp_flag_o);
    idle();
    tick();

    // Conflict: main wins, multiply follows from the FIFO
    drive(1, 5, 32'hA, 1, 6, 32'hB, 0, 0);
    tick();
    chk("conf_c1_addr", rf_waddr,     5'd5);
    chk("conf_c1_data", rf_wdata,     32'hA);
    chk("conf_c1_from", rf_from_mult, 1'b0);
    idle();
    tick();
    chk("conf_c2_addr", rf_waddr,     5'd6);
    chk("conf_c2_data", rf_wdata,     32'hB);
    chk("conf_c2_from", rf_from_mult, 1'b1);
    tick();
    chk("conf_empty_we", rf_we,       1'b0);

    // Kill
    query_reg = 5'd7;
    drive(1, 1, 32'h100, 1, 7, 32'h1, 0, 0);
    tick();
    drive(1, 1, 32'h101, 0, 0, '0, 0, 0);
    #1;
    chk("kill_pending_before", pending_hit, 1'b1);
    tick();
    drive(1, 7, 32'h2, 0, 0, '0, 0, 0);
    #1;
    chk("kill_pending_during", pending_hit, 1'b0);
    tick();
    chk("kill_main_addr", rf_waddr, 5'd7);
    chk("kill_main_data", rf_wdata, 32'h2);
    idle();
    tick();
    chk("kill_pop_we",   rf_we,    1'b0);
    chk("kill_r7_final", rf_wdata, 32'h2);
    tick();
    chk("kill_after_afull", mult_afull, 1'b0);
    query_reg = '0;

    // Fill and overflow
    for (int k = 1; k <= 5; k++) begin
      drive(1, 10, DW'(32'h200 + k), 1, k, DW'(k * 32'h11), 0, 0);
      tick();
      if (k == 1) chk("fill_afull_c1", mult_afull, 1'b0);
      if (k == 2) chk("fill_afull_c2", mult_afull, 1'b1);
      if (k == 4) chk("fill_ovf_c4",   fifo_ovf,   1'b0);
    end
    chk("fill_ovf_set", fifo_ovf, 1'b1);
    idle();
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("drain_addr", rf_waddr, AW'(k));
      chk("drain_data", rf_wdata, DW'(k * 32'h11));
    end
    tick();
    chk("drain_done_we",    rf_we,      1'b0);
    chk("drain_done_afull", mult_afull, 1'b0);
    chk("drain_ovf_sticky", fifo_ovf,   1'b1);

    // Register 0
    drive(1, 0, 32'h55, 1, 0, 32'h66, 0, 0);
    tick();
    chk("r0_we", rf_we, 1'b0);
    idle();
    tick();
    chk("r0_count_we", rf_we, 1'b0);

    // Reset mid-drain
    for (int k = 1; k <= 3; k++) begin
      drive(1, 20, DW'(k), 1, k + 1, DW'(32'h300 + k), 0, 0);
      tick();
    end
    idle();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we",    rf_we,      1'b0);
    chk("rst_mid_afull", mult_afull, 1'b0);
    chk("rst_mid_ovf",   fifo_ovf,   1'b0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_after_we", rf_we, 1'b0);
    end

    // Randomized traffic checked by the compare process
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
            ($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 1));
      query_reg = AW'($urandom_range(0, 7));
      tick();
    end
    idle();
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
